mem_stage_param: RTL
====================

# mem_stage_param

Parametrised memory stage of the 5-stage pipeline, between execute and writeback. Performs loads and stores against an internal word-addressed data memory with a configurable number of wait states. Passes ALU results through unchanged. Stalls the upstream pipeline while an access is in progress and flags out-of-range addresses. Registers the stage result, op, destination register and valid/error flags into the MEM/WB latch.

## Interface
Parameters:
- DW, 16: data and address width.
- DEPTH, 129: memory words; legal addresses 0..DEPTH-1.
- RW, 3: destination-register index width.
- WAIT_CYCLES, 0: extra cycles per load/store (0..15).

Ports:
- CLOCK_50  in  1  clock; all state updates on posedge.
- RESET  in  1  reset, asynchronous, active-high.
- VALID_IN  in  1  instruction present on the inputs this cycle.
- OP_IN  in  2  2'b10 load, 2'b11 store, 2'b0x pass-through.
- ADDR  in  DW  memory address, or ALU result for pass-through.
- DATAIN  in  DW  store data.
- DESTREG_IN  in  RW  destination register.
- STALL  out  1  combinational; upstream holds all inputs while high.
- MEM_RESULT  out  DW  combinational copy of DATAIN (forwarding path).
- OP_OUT  out  2  combinational copy of OP_IN.
- VALID_OUT  out  1  registered; latch holds a completed instruction.
- LATCHDATAOUT  out  DW  registered; load data or pass-through ADDR.
- LATCHOPOUT  out  2  registered op.
- DESTREG_OUT  out  RW  registered destination register.
- ERR_OUT  out  1  registered; the completed access was out of range.

## Operation
- memop = VALID_IN & OP_IN[1]; oor = memop & (ADDR >= DEPTH).
- The wait counter cnt (4 bits) counts wait states elapsed. STALL = memop & (cnt != WAIT_CYCLES).
- While STALL is high, cnt increments each edge. The latch loads VALID_OUT=0 (bubble), and the other latch fields are don't-care.
- Completion edge: a valid instruction with STALL low.
  - cnt returns to 0.
  - The latch loads VALID_OUT=1, LATCHOPOUT=OP_IN, DESTREG_OUT=DESTREG_IN and ERR_OUT=oor.
- LATCHDATAOUT on the completion edge:
  - load, in range: mem[ADDR].
  - load, out of range: 0.
  - store: ADDR.
  - pass-through: ADDR.
- Store writes mem[ADDR] <= DATAIN only on the completion edge and only if in range. An out-of-range store writes nothing and sets ERR_OUT.
- VALID_IN low: the latch loads a bubble (VALID_OUT=0, other fields 0) and cnt clears.
- VALID_IN dropping mid-stall is an upstream protocol violation. The access is aborted: cnt clears and no write occurs.
- Memory contents are not reset. They are undefined until written.

## Timing
- Reset values: VALID_OUT 0, LATCHDATAOUT 0, LATCHOPOUT 0, DESTREG_OUT 0, ERR_OUT 0, cnt 0. STALL follows its equation with cnt=0.
- Pass-through ops, and any op when WAIT_CYCLES=0: one cycle. Inputs in cycle n appear on the latch outputs in cycle n+1. STALL is never asserted.
- Memory op with WAIT_CYCLES=W: STALL is high in cycles n..n+W-1 and low in cycle n+W. The result is registered at the end of cycle n+W and is visible in cycle n+W+1.
- Back-to-back memory ops: the next op is presented in cycle n+W+1 and starts with cnt=0.
- A load in cycle n sees a store completed on any earlier edge. A load and store on the same edge cannot occur, because there is one op per cycle.
- RESET mid-stall: the access is aborted and no write occurs. After release, the held instruction restarts from cnt=0.

## Structure
- The shared pipeline package holds:
  - op codes OP_LOAD=2'b10 and OP_STORE=2'b11;
  - the pass-through test (OP_IN[1]==0);
  - the default widths DW=16 and RW=3.
- One sub-module, mem_pipe_reg, implements the MEM/WB latch. It is parametrised by DW and RW, has an asynchronous reset, and holds valid, data, op, dest and err.
- The FSM (cnt), memory array and address-range check live in the top module.

## Test plan
- Reset, then W=0: store DATAIN=16'hBEEF to ADDR=5, then load ADDR=5 with DEST=3 -> the next cycle shows LATCHDATAOUT=16'hBEEF, DESTREG_OUT=3, VALID_OUT=1, ERR_OUT=0, STALL never high.
- W=3: load ADDR=7, previously written 16'h1234 -> STALL high for exactly 3 cycles, VALID_OUT=0 during them, then VALID_OUT=1 with 16'h1234.
- Pass-through op 2'b00 with ADDR=16'h00AA under W=3 -> no STALL, LATCHDATAOUT=16'h00AA the next cycle.
- Store to ADDR=200 (DEPTH=129) -> ERR_OUT=1, mem[200 mod 129] unchanged. A subsequent load of ADDR=200 -> data 0, ERR_OUT=1.
- W=4: assert RESET during the second stall cycle of a store of 16'h5555 to ADDR=9 -> all outputs 0 and mem[9] unchanged. After release the store completes in 4 wait cycles.
- VALID_IN=0 for two cycles between loads -> two bubbles (VALID_OUT=0), and the following load returns correct data.

Source files
------------

// File: rtl/mem_stage_param_pkg.sv
// Shared pipeline definitions: op codes, default widths and the pass-through test.
// Imported by the memory stage and its MEM/WB latch.
package mem_stage_param_pkg;

    typedef logic [1:0] op_t;

    localparam int  DW_DEFAULT = 16;
    localparam int  RW_DEFAULT = 3;

    localparam op_t OP_LOAD  = 2'b10;
    localparam op_t OP_STORE = 2'b11;

    function automatic logic is_passthru(input op_t op);
        return ~op[1];
    endfunction

endpackage

// File: rtl/mem_stage_param_pipe_reg.sv
// MEM/WB pipeline latch: holds valid, result data, op, destination register and error flag.
// Cleared asynchronously so a reset mid-access leaves a clean bubble.
module mem_pipe_reg
    import mem_stage_param_pkg::*;
#(
    parameter int DW = DW_DEFAULT,
    parameter int RW = RW_DEFAULT
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          valid_i,
    input  logic [DW-1:0] data_i,
    input  op_t           op_i,
    input  logic [RW-1:0] dest_i,
    input  logic          err_i,
    output logic          valid_o,
    output logic [DW-1:0] data_o,
    output op_t           op_o,
    output logic [RW-1:0] dest_o,
    output logic          err_o
);

    logic          valid_q;
    logic [DW-1:0] data_q;
    op_t           op_q;
    logic [RW-1:0] dest_q;
    logic          err_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            op_q    <= '0;
            dest_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            valid_q <= valid_i;
            data_q  <= data_i;
            op_q    <= op_i;
            dest_q  <= dest_i;
            err_q   <= err_i;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign op_o    = op_q;
    assign dest_o  = dest_q;
    assign err_o   = err_q;

endmodule

// File: rtl/mem_stage_param.sv
// Pipeline memory stage: loads/stores against a word-addressed memory with configurable
// wait states, ALU pass-through, upstream stall and out-of-range flagging.
module mem_stage_param
    import mem_stage_param_pkg::*;
#(
    parameter int DW          = DW_DEFAULT,
    parameter int DEPTH       = 129,
    parameter int RW          = RW_DEFAULT,
    parameter int WAIT_CYCLES = 0
) (
    input  logic          CLOCK_50,
    input  logic          RESET,
    input  logic          VALID_IN,
    input  op_t           OP_IN,
    input  logic [DW-1:0] ADDR,
    input  logic [DW-1:0] DATAIN,
    input  logic [RW-1:0] DESTREG_IN,
    output logic          STALL,
    output logic [DW-1:0] MEM_RESULT,
    output op_t           OP_OUT,
    output logic          VALID_OUT,
    output logic [DW-1:0] LATCHDATAOUT,
    output op_t           LATCHOPOUT,
    output logic [RW-1:0] DESTREG_OUT,
    output logic          ERR_OUT
);

    localparam int           AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]   WAIT_LAST = 4'(WAIT_CYCLES);
    // One extra bit so a depth of exactly 2**DW still compares correctly.
    localparam logic [DW:0]  DEPTH_X   = (DW+1)'(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [3:0]    cnt_q, cnt_d;

    logic          memop, oor, done, mem_we;
    logic [AW-1:0] mem_idx;
    logic [DW-1:0] rd_data;
    logic          lat_valid_d, lat_err_d;
    logic [DW-1:0] lat_data_d;
    op_t           lat_op_d;
    logic [RW-1:0] lat_dest_d;

    assign memop      = VALID_IN & ~is_passthru(OP_IN);
    assign oor        = memop & ({1'b0, ADDR} >= DEPTH_X);
    assign mem_idx    = ADDR[AW-1:0];
    assign MEM_RESULT = DATAIN;
    assign OP_OUT     = OP_IN;

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Counter only advances while stalled; completion, bubbles and aborts all return it to 0.
    always_comb begin
        cnt_d = '0;
        if (STALL) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    always_comb begin
        STALL       = memop && (cnt_q != WAIT_LAST);
        done        = VALID_IN && !STALL;
        mem_we      = done && (OP_IN == OP_STORE) && !oor && !RESET;
        rd_data     = oor ? '0 : mem_q[mem_idx];
        lat_valid_d = done;
        lat_data_d  = '0;
        lat_op_d    = '0;
        lat_dest_d  = '0;
        lat_err_d   = 1'b0;
        if (done) begin
            lat_data_d = (OP_IN == OP_LOAD) ? rd_data : ADDR;
            lat_op_d   = OP_IN;
            lat_dest_d = DESTREG_IN;
            lat_err_d  = oor;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (mem_we) begin
            mem_q[mem_idx] <= DATAIN;
        end
    end

    mem_pipe_reg #(
        .DW (DW),
        .RW (RW)
    ) u_pipe_reg (
        .clk_i   (CLOCK_50),
        .rst_i   (RESET),
        .valid_i (lat_valid_d),
        .data_i  (lat_data_d),
        .op_i    (lat_op_d),
        .dest_i  (lat_dest_d),
        .err_i   (lat_err_d),
        .valid_o (VALID_OUT),
        .data_o  (LATCHDATAOUT),
        .op_o    (LATCHOPOUT),
        .dest_o  (DESTREG_OUT),
        .err_o   (ERR_OUT)
    );

endmodule
